// File: rtl/pipe_pkg.sv
// pipe_pkg: shared state encoding and widths for the elastic pipeline stage register
package pipe_pkg;
  localparam int OCC_W = 2;
  typedef enum logic [1:0] {ST_EMPTY = 2'd0, ST_FULL = 2'd1, ST_SKID = 2'd2} state_t;
endpackage

// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: valid/ready pipeline register with flush; skid entry when PIPE_SKID_EN is defined
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [OCC_W-1:0] occupancy
);
  state_t state_q, state_d;
  logic [WIDTH-1:0] main_q, main_d;
  logic in_fire, out_fire;
  assign out_valid = state_q != ST_EMPTY;
  assign out_data  = main_q;
  assign occupancy = state_q;
  assign in_fire   = in_valid & in_ready;
  assign out_fire  = out_valid & out_ready;
`ifdef PIPE_SKID_EN
  logic [WIDTH-1:0] skid_q, skid_d;
  // in_ready comes only from state so downstream stalls never reach upstream combinationally
  assign in_ready = !rst & (state_q != ST_SKID);
  // next state and data; head always lives in main so out_data needs no output mux
  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    if (flush) state_d = ST_EMPTY;
    else case (state_q)
      ST_EMPTY: if (in_fire) begin
        state_d = ST_FULL;
        main_d  = in_data;
      end
      ST_FULL: if (in_fire && out_fire) main_d = in_data;
      else if (in_fire) begin
        state_d = ST_SKID;
        skid_d  = in_data;
      end else if (out_fire) state_d = ST_EMPTY;
      ST_SKID: if (out_fire) begin
        state_d = ST_FULL;
        main_d  = skid_q;
      end
      default: state_d = ST_EMPTY;
    endcase
  end
  // state and data registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_EMPTY;
      main_q  <= RST_VAL;
      skid_q  <= RST_VAL;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
    end
  end
`else
  assign in_ready = !rst & (!out_valid | out_ready);
  // single-entry stage: load on accept, drain on output fire, flush only drops validity
  always_comb begin
    main_d  = in_fire && !flush ? in_data : main_q;
    state_d = flush ? ST_EMPTY : in_fire ? ST_FULL : out_fire ? ST_EMPTY : state_q;
  end
  // state and data registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_EMPTY;
      main_q  <= RST_VAL;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
    end
  end
`endif
endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb_pipe_stage_reg: directed and random checks of pipe_stage_reg against a FIFO queue model
module tb_pipe_stage_reg;
  localparam int W = 16;
  localparam logic [W-1:0] RV = 16'hBEEF;
`ifdef PIPE_SKID_EN
  localparam int CAP = 2;
`else
  localparam int CAP = 1;
`endif
  logic clk = 0, rst, flush, in_valid, in_ready, out_valid, out_ready;
  logic [W-1:0] in_data, out_data;
  logic [1:0] occupancy;
  int tests = 0, fails = 0;
  logic [W-1:0] q[$];
  logic [W-1:0] last;
  pipe_stage_reg #(.WIDTH(W), .RST_VAL(RV)) dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .occupancy(occupancy)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s at %0t: got %h expected %h", tag, $time, got, exp);
    end
  endtask
  task automatic step(input logic r, input logic f, input logic iv, input logic [W-1:0] d, input logic od);
    logic er;
    int n;
    @(negedge clk);
    rst = r; flush = f; in_valid = iv; in_data = d; out_ready = od;
    #1;
    n  = q.size();
    er = !r && (CAP == 2 ? n < 2 : (n == 0 || od));
    chk("in_ready", 32'(in_ready), 32'(er));
    chk("out_valid", 32'(out_valid), 32'(n > 0));
    chk("occupancy", 32'(occupancy), 32'(n));
    chk("out_data", 32'(out_data), 32'(n > 0 ? q[0] : last));
    @(posedge clk);
    if (n > 0) last = q[0];
    if (r) begin
      q.delete();
      last = RV;
    end else if (f) q.delete();
    else begin
      if (n > 0 && od) void'(q.pop_front());
      if (iv && er) q.push_back(d);
    end
  endtask
  initial begin
    logic iv;
    rst = 1; flush = 0; in_valid = 1; in_data = 16'hDEAD; out_ready = 0;
    @(posedge clk);
    q.delete();
    last = RV;
    repeat (2) step(1, 0, 1, 16'hDEAD, 0);
    for (int i = 1; i <= 8; i++) step(0, 0, 1, W'(i), 1);
    step(0, 0, 0, '0, 1);
    step(0, 0, 0, '0, 1);
    step(0, 0, 1, 16'hA, 1);
    step(0, 0, 1, 16'hB, 0);
    step(0, 0, 1, 16'hC, 0);
    step(0, 0, 1, 16'hC, 0);
    step(0, 0, 1, 16'hC, 1);
    step(0, 0, 1, 16'hC, 1);
    step(0, 0, 0, '0, 1);
    step(0, 0, 0, '0, 1);
    step(0, 0, 1, 16'h5, 0);
    step(0, 0, 1, 16'h6, 0);
    step(0, 1, 1, 16'h7, 0);
    step(0, 0, 0, '0, 0);
    step(0, 0, 0, '0, 1);
    step(0, 0, 0, '0, 1);
    step(0, 0, 1, 16'h11, 0);
    step(0, 0, 1, 16'h12, 0);
    step(1, 0, 1, 16'h13, 1);
    step(0, 0, 0, '0, 1);
    step(0, 0, 0, '0, 1);
    for (int i = 0; i < 10000; i++) begin
      iv = 1'($urandom);
      step($urandom_range(0, 499) == 0, $urandom_range(0, 49) == 0, iv,
           iv ? W'($urandom) : 'x, 1'($urandom));
      tests++;
      assert (int'(occupancy) <= CAP) else begin
        fails++;
        $error("FAIL occ_bound: got %0d expected <= %0d", occupancy, CAP);
      end
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
